// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states, byte-masked stores.
// Optional address-error checking is enabled by defining DMEM_RESP_ERR_CHECK_EN.
module dmem_responder #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_be_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ready_q, ready_d;
    logic            valid_q, valid_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;
    logic            we_q, we_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [3:0]      be_q, be_d;

    logic [31:0]     mem_q [DEPTH];

    logic            acc_we;
    logic [31:0]     acc_addr;
    logic [31:0]     acc_wdata;
    logic [3:0]      acc_be;
    logic [AW-1:0]   acc_idx;
    logic            acc_err;
    logic            enter_resp;
    logic            mem_we;
    logic [31:0]     mem_wword;

    // With zero wait states RESP is entered on the acceptance edge, before the latches load.
    always_comb begin
        if (state_q == ST_IDLE) begin
            acc_we    = req_we_i;
            acc_addr  = req_addr_i;
            acc_wdata = req_wdata_i;
            acc_be    = req_be_i;
        end else begin
            acc_we    = we_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_be    = be_q;
        end
        acc_idx = acc_addr[AW+1:2];
    end

`ifdef DMEM_RESP_ERR_CHECK_EN
    assign acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr[31:2] >= 30'(DEPTH));
`else
    logic unused_addr_bits;
    assign acc_err          = 1'b0;
    assign unused_addr_bits = ^{acc_addr[31:AW+2], acc_addr[1:0]};
`endif

    // Next-state, counter, request latches and registered response outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        valid_d    = 1'b0;
        rdata_d    = '0;
        err_d      = 1'b0;
        enter_resp = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i && ready_q) begin
                    we_d    = req_we_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    be_d    = req_be_i;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CW'(WAIT_CYCLES - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE);

        if (enter_resp) begin
            valid_d = 1'b1;
            err_d   = acc_err;
            rdata_d = (!acc_we && !acc_err) ? mem_q[acc_idx] : '0;
        end
    end

    // Store merge: only enabled byte lanes take new data.
    always_comb begin
        mem_wword = mem_q[acc_idx];
        for (int b = 0; b < 4; b++) begin
            if (acc_be[b]) begin
                mem_wword[8*b +: 8] = acc_wdata[8*b +: 8];
            end
        end
        mem_we = enter_resp && acc_we && !acc_err && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
        end
    end

    // Array contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[acc_idx] <= mem_wword;
        end
    end

    assign req_ready_o = ready_q;
    assign rsp_valid_o = valid_q;
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance
// sharing request inputs; expectations follow DMEM_RESP_ERR_CHECK_EN when defined.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;

    logic        d2_ready, d2_valid, d2_err;
    logic [31:0] d2_rdata;
    logic        d0_ready, d0_valid, d0_err;
    logic [31:0] d0_rdata;

    logic        sel0;
    logic        rdy_m, vld_m, err_m;
    logic [31:0] rdata_m;

    int vec  = 0;
    int errs = 0;

    always #5 clk = ~clk;

    assign rdy_m   = sel0 ? d0_ready : d2_ready;
    assign vld_m   = sel0 ? d0_valid : d2_valid;
    assign err_m   = sel0 ? d0_err   : d2_err;
    assign rdata_m = sel0 ? d0_rdata : d2_rdata;

    dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(d2_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
        .rsp_valid_o(d2_valid), .rsp_rdata_o(d2_rdata), .rsp_err_o(d2_err)
    );

    dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(d0_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
        .rsp_valid_o(d0_valid), .rsp_rdata_o(d0_rdata), .rsp_err_o(d0_err)
    );

    // Drives one request and measures it; lat = edges from acceptance to the response cycle, 0 on timeout.
    task automatic issue(input bit use0, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         output logic [31:0] rdata, output logic err, output int lat,
                         output int low, output logic post_rdy, output logic post_vld,
                         output logic [31:0] post_rdata);
        sel0 = use0;
        req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        req_valid = 1'b1;
        for (int n = 0; n < 32 && !rdy_m; n++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'b0;
        lat = 0; low = 0; rdata = '0; err = 1'b0;
        for (int k = 0; k < 32; k++) begin
            if (!rdy_m) low++;
            if (vld_m) begin
                lat = k + 1; rdata = rdata_m; err = err_m;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        post_rdy = rdy_m; post_vld = vld_m; post_rdata = rdata_m;
    endtask

    logic [31:0] rd, prd;
    logic        er, prdy, pvld;
    int          lat, low;

    task automatic test_reset();
        int pulses;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        sel0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vec++; if ({d2_ready, d2_valid, d2_err, d2_rdata} !== 35'd0) begin
            $display("FAIL reset_outputs: got rdy=%b vld=%b err=%b rdata=%h want all 0",
                     d2_ready, d2_valid, d2_err, d2_rdata); errs++; end
        rst = 1'b0;
        @(posedge clk); #1;
        vec++; if (d2_ready !== 1'b1) begin
            $display("FAIL ready_after_reset: got %b want 1", d2_ready); errs++; end
        vec++; if (d0_ready !== 1'b1) begin
            $display("FAIL ready_after_reset_w0: got %b want 1", d0_ready); errs++; end
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            if (d2_valid || d0_valid) pulses++;
            @(posedge clk); #1;
        end
        vec++; if (pulses !== 0) begin
            $display("FAIL idle_no_pulse: got %0d pulses want 0", pulses); errs++; end
    endtask

    task automatic test_store_load();
        issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat, low, prdy, pvld, prd);
        vec++; if (lat !== 3) begin
            $display("FAIL store_latency: got %0d want 3", lat); errs++; end
        vec++; if (er !== 1'b0 || rd !== 32'h0) begin
            $display("FAIL store_rsp: got err=%b rdata=%h want err=0 rdata=0", er, rd); errs++; end
        vec++; if (low !== 3) begin
            $display("FAIL ready_low_cycles: got %0d want 3", low); errs++; end
        vec++; if (prdy !== 1'b1 || pvld !== 1'b0 || prd !== 32'h0) begin
            $display("FAIL post_rsp: got rdy=%b vld=%b rdata=%h want 1 0 0", prdy, pvld, prd); errs++; end
        issue(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, low, prdy, pvld, prd);
        vec++; if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat !== 3) begin
            $display("FAIL load_0x10: got rdata=%h err=%b lat=%0d want DEADBEEF 0 3", rd, er, lat); errs++; end
        // Next acceptance is possible 4 edges after the previous one.
        vec++; if (lat + 1 !== 4) begin
            $display("FAIL issue_interval: got %0d want 4", lat + 1); errs++; end
    endtask

    task automatic test_byte_lanes();
        issue(1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, lat, low, prdy, pvld, prd);
        issue(1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, er, lat, low, prdy, pvld, prd);
        issue(1'b0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat, low, prdy, pvld, prd);
        vec++; if (rd !== 32'h11BB33DD) begin
            $display("FAIL byte_lanes: got %h want 11BB33DD", rd); errs++; end
        issue(1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, rd, er, lat, low, prdy, pvld, prd);
        vec++; if (lat !== 3 || er !== 1'b0) begin
            $display("FAIL be_zero_rsp: got lat=%0d err=%b want 3 0", lat, er); errs++; end
        issue(1'b0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat, low, prdy, pvld, prd);
        vec++; if (rd !== 32'h11BB33DD) begin
            $display("FAIL be_zero_nowrite: got %h want 11BB33DD", rd); errs++; end
    endtask

    task automatic test_back_to_back();
        int hs_cnt, pulses;
        logic hs;
        sel0 = 1'b1;
        for (int n = 0; n < 32 && !d0_ready; n++) begin
            @(posedge clk); #1;
        end
        req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h12345678; req_be = 4'hF;
        req_valid = 1'b1;
        hs_cnt = 0; pulses = 0;
        for (int i = 0; i < 6; i++) begin
            hs = req_valid && d0_ready;
            @(posedge clk); #1;
            if (d0_valid) pulses++;
            if (hs) begin
                hs_cnt++;
                vec++; if (d0_valid !== 1'b1) begin
                    $display("FAIL b2b_rsp_after_accept: got %b want 1 (cycle %0d)", d0_valid, i); errs++; end
            end
        end
        req_valid = 1'b0; req_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (d0_valid) pulses++;
        end
        vec++; if (hs_cnt !== 3) begin
            $display("FAIL b2b_handshakes: got %0d want 3", hs_cnt); errs++; end
        vec++; if (pulses !== 3) begin
            $display("FAIL b2b_pulses: got %0d want 3", pulses); errs++; end
        issue(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat, low, prdy, pvld, prd);
        vec++; if (rd !== 32'h12345678 || lat !== 1) begin
            $display("FAIL w0_load: got rdata=%h lat=%0d want 12345678 1", rd, lat); errs++; end
        sel0 = 1'b0;
    endtask

    task automatic test_addr_err();
        logic        exp_err;
        logic [31:0] exp_w0;
`ifdef DMEM_RESP_ERR_CHECK_EN
        exp_err = 1'b1; exp_w0 = 32'hCAFEF00D;
`else
        exp_err = 1'b0; exp_w0 = 32'h0BADF00D;
`endif
        issue(1'b0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, rd, er, lat, low, prdy, pvld, prd);
        issue(1'b0, 1'b1, 32'h1002, 32'h0BADF00D, 4'hF, rd, er, lat, low, prdy, pvld, prd);
        vec++; if (er !== exp_err || rd !== 32'h0 || lat !== 3) begin
            $display("FAIL err_misaligned: got err=%b rdata=%h lat=%0d want %b 0 3", er, rd, lat, exp_err); errs++; end
        vec++; if (prdy !== 1'b1 || pvld !== 1'b0 || prd !== 32'h0) begin
            $display("FAIL err_post: got rdy=%b vld=%b rdata=%h want 1 0 0", prdy, pvld, prd); errs++; end
`ifdef DMEM_RESP_ERR_CHECK_EN
        issue(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat, low, prdy, pvld, prd);
        vec++; if (rd !== 32'hCAFEF00D) begin
            $display("FAIL misaligned_nowrite: got %h want CAFEF00D", rd); errs++; end
`endif
        issue(1'b0, 1'b1, 32'h1000, 32'h0BADF00D, 4'hF, rd, er, lat, low, prdy, pvld, prd);
        vec++; if (er !== exp_err) begin
            $display("FAIL err_range: got %b want %b", er, exp_err); errs++; end
        issue(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat, low, prdy, pvld, prd);
        vec++; if (rd !== exp_w0 || er !== 1'b0) begin
            $display("FAIL word0_after_range: got %h err=%b want %h 0", rd, er, exp_w0); errs++; end
    endtask

    task automatic test_reset_mid();
        int pulses;
        issue(1'b0, 1'b1, 32'h30, 32'h5, 4'hF, rd, er, lat, low, prdy, pvld, prd);
        // Reset sampled during WAIT, then at the edge that would enter RESP.
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 32 && !d2_ready; n++) begin
                @(posedge clk); #1;
            end
            req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h99; req_be = 4'hF;
            req_valid = 1'b1;
            @(posedge clk); #1;
            req_valid = 1'b0; req_we = 1'b0;
            if (d == 1) begin
                @(posedge clk); #1;
            end
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            pulses = 0;
            for (int i = 0; i < 6; i++) begin
                if (d2_valid) pulses++;
                @(posedge clk); #1;
            end
            vec++; if (pulses !== 0) begin
                $display("FAIL mid_reset_pulse: got %0d pulses want 0 (case %0d)", pulses, d); errs++; end
        end
        issue(1'b0, 1'b0, 32'h30, 32'h0, 4'h0, rd, er, lat, low, prdy, pvld, prd);
        vec++; if (rd !== 32'h5 || lat !== 3) begin
            $display("FAIL mid_reset_nowrite: got rdata=%h lat=%0d want 5 3", rd, lat); errs++; end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byte_lanes();
        test_back_to_back();
        test_addr_err();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
